// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution MAC scheduler.
//   state_t : scheduler FSM states
//   tag_t   : per-chunk tag carried alongside the SRAM/MAC pipeline
//   *_DEF   : default widths/depths used by the top and the result FIFO
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam int unsigned OFM_W_DEF     = 13;
    localparam int unsigned ACC_W_DEF     = 17;
    localparam int unsigned OUT_DEPTH_DEF = 4;

    typedef struct packed {
        logic v;      // chunk valid
        logic first;  // first chunk of a pixel: restart accumulation
        logic last;   // last chunk of a pixel: push result
    } tag_t;

endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO with occupancy count.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push/push_data write side (caller guarantees no push when full)
//   pop            read side, caller qualifies with valid
//   pop_data       head entry, 0 when empty
//   valid          FIFO not empty
//   count          current occupancy (0..DEPTH)
module conv_res_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign valid    = (count != '0);
    assign do_pop   = pop && valid;
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_mac_scheduler.sv
// Sequencer for the 32-lane 4-bit convolution MAC array.
// Issues one IFM/weight chunk read per cycle, tracks chunks through the
// SRAM + MAC latency with a tag pipe, accumulates K partial sums per pixel
// and queues finished pixels in a small FIFO toward writeback.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, cfg_num_pix/chunk      job start (IDLE only) and job shape
//   busy, done                    job status, done is a one-cycle pulse
//   ifm_rd_en/addr, wgt_rd_en/addr SRAM read requests
//   mac_in_valid/weight_valid     MAC register loads (rd_en delayed RD_LAT)
//   mac_ofm                       MAC partial sum
//   res_valid/ready/data          result stream (FIFO head)
//   stall_cnt                     credit-stall cycles
// Optional: define CONV_SCHED_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt is tied to 0.
module conv_mac_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAC_LAT   = 4,
    parameter int unsigned OFM_W     = OFM_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned IFM_AW    = 12,
    parameter int unsigned WGT_AW    = 4,
    parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        cfg_num_pix,
    input  logic [3:0]        cfg_num_chunk,
    output logic              busy,
    output logic              done,
    output logic              ifm_rd_en,
    output logic [IFM_AW-1:0] ifm_rd_addr,
    output logic              wgt_rd_en,
    output logic [WGT_AW-1:0] wgt_rd_addr,
    output logic              mac_in_valid,
    output logic              mac_weight_valid,
    input  logic [OFM_W-1:0]  mac_ofm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PIPE_D = RD_LAT + MAC_LAT;
    localparam int unsigned CW     = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);

    state_t            state;
    logic [7:0]        n_pix;
    logic [7:0]        pix;
    logic [3:0]        n_chunk;
    logic [3:0]        k;
    logic [IFM_AW-1:0] addr_cnt;
    logic              rd_en_q;
    logic              first_q;
    logic              last_q;
    logic [CW-1:0]     credit;
    logic              issue_now;
    logic              first_issue;
    logic              pop;
    logic              pipe_busy;

    tag_t              pipe [PIPE_D];
    tag_t              tail;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  ofm_ext;
    logic [ACC_W-1:0]  sum;
    logic              push;
    logic [CW-1:0]     fifo_count;

    assign ifm_rd_en = rd_en_q;
    assign wgt_rd_en = rd_en_q;

    // Credit covers pixels in flight plus FIFO occupancy; only a pixel's first
    // chunk needs it, later chunks of a started pixel always go.
    assign issue_now   = (state == ST_ISSUE) && ((k != '0) || (credit < CREDIT_MAX));
    assign first_issue = issue_now && (k == '0);
    assign pop         = res_valid && res_ready;

    always_comb begin
        pipe_busy = rd_en_q;
        for (int unsigned i = 0; i < PIPE_D; i++) begin
            pipe_busy = pipe_busy | pipe[i].v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            n_pix       <= '0;
            n_chunk     <= '0;
            pix         <= '0;
            k           <= '0;
            addr_cnt    <= '0;
            rd_en_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            ifm_rd_addr <= '0;
            wgt_rd_addr <= '0;
        end else begin
            done    <= 1'b0;
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        n_pix    <= cfg_num_pix;
                        n_chunk  <= cfg_num_chunk;
                        pix      <= '0;
                        k        <= '0;
                        addr_cnt <= '0;
                        if ((cfg_num_pix == '0) || (cfg_num_chunk == '0)) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_now) begin
                        rd_en_q     <= 1'b1;
                        ifm_rd_addr <= addr_cnt;
                        wgt_rd_addr <= WGT_AW'(k);
                        addr_cnt    <= addr_cnt + 1'b1;
                        first_q     <= (k == '0);
                        last_q      <= (k == n_chunk - 4'd1);
                        if (k == n_chunk - 4'd1) begin
                            k   <= '0;
                            pix <= pix + 8'd1;
                            if (pix == n_pix - 8'd1) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // rd_en_q covers the final chunk before it enters the pipe.
                    if (!pipe_busy && !res_valid) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            unique case ({first_issue, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Tag pipe: stage i holds the chunk whose rd_en was high i+1 cycles ago,
    // so the last stage lines up with its mac_ofm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_D; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{v: rd_en_q, first: first_q, last: last_q};
            for (int unsigned i = 1; i < PIPE_D; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_mv_direct
            assign mac_in_valid     = rd_en_q;
            assign mac_weight_valid = rd_en_q;
        end else begin : g_mv_pipe
            assign mac_in_valid     = pipe[RD_LAT-1].v;
            assign mac_weight_valid = pipe[RD_LAT-1].v;
        end
    endgenerate

    assign tail    = pipe[PIPE_D-1];
    assign ofm_ext = {{(ACC_W-OFM_W){1'b0}}, mac_ofm};
    assign sum     = tail.first ? ofm_ext : (acc + ofm_ext);
    assign push    = tail.v && tail.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (tail.v) begin
            acc <= sum;
        end
    end

    conv_res_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sum),
        .pop       (pop),
        .pop_data  (res_data),
        .valid     (res_valid),
        .count     (fifo_count)
    );

`ifdef CONV_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            stall_q <= '0;
        end else if ((state == ST_ISSUE) && !issue_now && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_mac_scheduler.sv
module tb_conv_mac_scheduler;

    localparam int RD_LAT    = 1;
    localparam int MAC_LAT   = 4;
    localparam int D         = RD_LAT + MAC_LAT;
    localparam int OUT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_num_pix;
    logic [3:0]  cfg_num_chunk;
    logic        busy, done;
    logic        ifm_rd_en, wgt_rd_en;
    logic [11:0] ifm_rd_addr;
    logic [3:0]  wgt_rd_addr;
    logic        mac_in_valid, mac_weight_valid;
    logic [12:0] mac_ofm;
    logic        res_valid, res_ready;
    logic [16:0] res_data;
    logic [15:0] stall_cnt;

    conv_mac_scheduler #(
        .RD_LAT  (RD_LAT),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_num_pix      (cfg_num_pix),
        .cfg_num_chunk    (cfg_num_chunk),
        .busy             (busy),
        .done             (done),
        .ifm_rd_en        (ifm_rd_en),
        .ifm_rd_addr      (ifm_rd_addr),
        .wgt_rd_en        (wgt_rd_en),
        .wgt_rd_addr      (wgt_rd_addr),
        .mac_in_valid     (mac_in_valid),
        .mac_weight_valid (mac_weight_valid),
        .mac_ofm          (mac_ofm),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .stall_cnt        (stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM contents seen by the MAC model
    logic [127:0] ifm_mem [256];
    logic [127:0] wgt_mem [16];

    function automatic int dot(input logic [127:0] a, input logic [127:0] b);
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(a[4*i +: 4]) * int'(b[4*i +: 4]);
        return s;
    endfunction

    // Reference pixel result: sum over its K chunks of the lane dot products
    function automatic int exp_pix(input int p, input int kk);
        int s = 0;
        for (int c = 0; c < kk; c++) s += dot(ifm_mem[(p*kk + c) % 256], wgt_mem[c]);
        return s;
    endfunction

    // ---------------- monitor / SRAM+MAC model ----------------
    logic [12:0] line [0:D];
    logic        rdh  [0:RD_LAT];
    int          iss_addr[$], iss_wgt[$], iss_cyc[$];
    logic [16:0] pop_q[$];
    int          m_n = 0, m_k = 0, m_issued = 0, m_firsts = 0, m_pops = 0, m_stall = 0;
    int          last_pop_cyc = 0;
    int          mv_err = 0, pair_err = 0, credit_err = 0, stab_err = 0;
    logic        hold_pending = 1'b0;
    logic [16:0] hold_data;

    always @(negedge clk) begin
        // combined SRAM + MAC latency: value appears D cycles after rd_en
        for (int i = D; i > 0; i--) line[i] = line[i-1];
        if (ifm_rd_en)
            line[0] = 13'(dot(ifm_mem[ifm_rd_addr[7:0]], wgt_mem[wgt_rd_addr]));
        else
            line[0] = 13'($urandom);
        mac_ofm = line[D];

        if (ifm_rd_en !== wgt_rd_en) pair_err++;

        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) rdh[i] = 1'b0;
            hold_pending = 1'b0;
        end else begin
            for (int i = RD_LAT; i > 0; i--) rdh[i] = rdh[i-1];
            rdh[0] = ifm_rd_en;
            if (mac_in_valid !== rdh[RD_LAT] || mac_weight_valid !== rdh[RD_LAT]) mv_err++;

            if (start && !busy) begin
                m_n = int'(cfg_num_pix); m_k = int'(cfg_num_chunk);
                m_issued = 0; m_firsts = 0; m_pops = 0; m_stall = 0;
                iss_addr.delete(); iss_wgt.delete(); iss_cyc.delete(); pop_q.delete();
            end

            if (ifm_rd_en) begin
                if (m_k != 0 && (m_issued % m_k) == 0) m_firsts++;
                m_issued++;
                iss_addr.push_back(int'(ifm_rd_addr));
                iss_wgt.push_back(int'(wgt_rd_addr));
                iss_cyc.push_back(cyc);
            end

            // next edge is a credit stall if a new pixel is due and the budget is used
            if (busy && m_k != 0 && m_n != 0 && m_issued < m_n * m_k &&
                (m_issued % m_k) == 0 && (m_firsts - m_pops) >= OUT_DEPTH)
                m_stall++;

            if ((m_firsts - m_pops) > OUT_DEPTH) credit_err++;

            if (hold_pending && (!res_valid || res_data !== hold_data)) stab_err++;
            hold_pending = res_valid && !res_ready;
            hold_data    = res_data;

            if (res_valid && res_ready) begin
                pop_q.push_back(res_data);
                m_pops++;
                last_pop_cyc = cyc;
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic fill_const(input logic [3:0] iv, input logic [3:0] wv);
        for (int i = 0; i < 256; i++) ifm_mem[i] = {32{iv}};
        for (int i = 0; i < 16; i++)  wgt_mem[i] = {32{wv}};
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) ifm_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++)  wgt_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic start_job(input int n, input int k);
        @(posedge clk); #1;
        cfg_num_pix = 8'(n); cfg_num_chunk = 4'(k); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
            if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; cfg_num_pix = '0; cfg_num_chunk = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, ifm_rd_en, wgt_rd_en, mac_in_valid, mac_weight_valid, res_valid} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {busy, done, ifm_rd_en, wgt_rd_en, mac_in_valid, mac_weight_valid, res_valid});
        end
        n_checks++;
        if (ifm_rd_addr !== '0 || wgt_rd_addr !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", ifm_rd_addr, wgt_rd_addr);
        end
        n_checks++;
        if (res_data !== '0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_data: got res_data=%0d stall_cnt=%0d expected 0", res_data, stall_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || ifm_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b rd_en=%b expected 0", busy, ifm_rd_en);
        end
    endtask

    task automatic test_basic();
        int d;
        fill_const(4'd1, 4'd1);
        res_ready = 1'b1;
        start_job(2, 3);
        wait_done(200, 1'b0, d);
        n_checks++;
        if (d < 0) begin n_fail++; $display("FAIL basic_timeout: no done within 200 cycles"); end
        n_checks++;
        if (pop_q.size() != 2) begin
            n_fail++; $display("FAIL basic_count: got %0d results expected 2", pop_q.size());
        end
        for (int i = 0; i < pop_q.size() && i < 2; i++) begin
            n_checks++;
            if (pop_q[i] !== 17'(exp_pix(i, 3))) begin
                n_fail++; $display("FAIL basic_res%0d: got %0d expected %0d", i, pop_q[i], exp_pix(i, 3));
            end
        end
        n_checks++;
        if (iss_addr.size() != 6) begin
            n_fail++; $display("FAIL basic_issues: got %0d expected 6", iss_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (iss_addr[i] != i || iss_wgt[i] != i % 3 || iss_cyc[i] != iss_cyc[0] + i) begin
                    n_fail++;
                    $display("FAIL basic_issue%0d: got addr=%0d wgt=%0d dcyc=%0d expected %0d/%0d/%0d",
                             i, iss_addr[i], iss_wgt[i], iss_cyc[i] - iss_cyc[0], i, i % 3, i);
                end
            end
        end
        n_checks++;
        if (d != last_pop_cyc + 2) begin
            n_fail++; $display("FAIL basic_done_timing: done at %0d expected %0d", d, last_pop_cyc + 2);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_done: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_max();
        int d;
        fill_const(4'hF, 4'hF);
        res_ready = 1'b1;
        start_job(1, 15);
        wait_done(300, 1'b0, d);
        n_checks++;
        if (d < 0 || pop_q.size() != 1) begin
            n_fail++; $display("FAIL max_count: done=%0d results=%0d expected 1 result", d, pop_q.size());
        end else if (pop_q[0] !== 17'(exp_pix(0, 15))) begin
            n_fail++; $display("FAIL max_value: got %0d expected %0d", pop_q[0], exp_pix(0, 15));
        end
    endtask

    task automatic test_credit();
        int d;
        fill_rand();
        res_ready = 1'b0;
        start_job(8, 1);
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (iss_addr.size() != OUT_DEPTH) begin
            n_fail++; $display("FAIL credit_issues: got %0d expected %0d", iss_addr.size(), OUT_DEPTH);
        end
        n_checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL credit_hold: res_valid=%b busy=%b expected 1/1", res_valid, busy);
        end
        res_ready = 1'b1;
        wait_done(300, 1'b0, d);
        n_checks++;
        if (d < 0 || pop_q.size() != 8) begin
            n_fail++; $display("FAIL credit_count: done=%0d results=%0d expected 8", d, pop_q.size());
        end
        for (int i = 0; i < pop_q.size() && i < 8; i++) begin
            n_checks++;
            if (pop_q[i] !== 17'(exp_pix(i, 1))) begin
                n_fail++; $display("FAIL credit_res%0d: got %0d expected %0d", i, pop_q[i], exp_pix(i, 1));
            end
        end
`ifdef CONV_SCHED_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'(m_stall) || stall_cnt == 16'd0) begin
            n_fail++; $display("FAIL credit_stall: got %0d expected %0d (nonzero)", stall_cnt, m_stall);
        end
`else
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL credit_stall: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_empty();
        int d, s;
        res_ready = 1'b1;
        start_job(0, 5);
        s = cyc;
        wait_done(3, 1'b0, d);
        n_checks++;
        if (d < 0 || d - s > 2) begin
            n_fail++; $display("FAIL empty_pix_done: done at %0d (start %0d) expected within 2", d, s);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (iss_addr.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL empty_pix_reads: got %0d reads busy=%b expected 0/0", iss_addr.size(), busy);
        end
        start_job(3, 0);
        s = cyc;
        wait_done(3, 1'b0, d);
        n_checks++;
        if (d < 0 || d - s > 2 || iss_addr.size() != 0) begin
            n_fail++; $display("FAIL empty_chunk: done at %0d (start %0d) reads=%0d expected done<=2 reads 0", d, s, iss_addr.size());
        end
    endtask

    task automatic test_start_ignored();
        int d;
        fill_const(4'd1, 4'd1);
        res_ready = 1'b1;
        start_job(2, 3);
        repeat (2) @(posedge clk);
        #1;
        cfg_num_pix = 8'd5; cfg_num_chunk = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, 1'b0, d);
        n_checks++;
        if (d < 0 || pop_q.size() != 2 || iss_addr.size() != 6) begin
            n_fail++; $display("FAIL ignore_start: done=%0d results=%0d reads=%0d expected 2 results 6 reads", d, pop_q.size(), iss_addr.size());
        end else if (pop_q[0] !== 17'(exp_pix(0, 3)) || pop_q[1] !== 17'(exp_pix(1, 3))) begin
            n_fail++; $display("FAIL ignore_start_val: got %0d,%0d expected %0d,%0d", pop_q[0], pop_q[1], exp_pix(0, 3), exp_pix(1, 3));
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int d, dn;
        fill_rand();
        res_ready = 1'b1;
        start_job(4, 2);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, ifm_rd_en, wgt_rd_en, mac_in_valid, mac_weight_valid, res_valid} !== 7'b0 ||
            ifm_rd_addr !== '0 || wgt_rd_addr !== '0 || res_data !== '0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: ctrl=%b addr=%0d/%0d data=%0d stall=%0d expected all 0",
                               {busy, done, ifm_rd_en, wgt_rd_en, mac_in_valid, mac_weight_valid, res_valid},
                               ifm_rd_addr, wgt_rd_addr, res_data, stall_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++; $display("FAIL midreset_no_done: got %0d done pulses expected 0", dn);
        end
        fill_const(4'd1, 4'd1);
        start_job(1, 1);
        wait_done(100, 1'b0, d);
        n_checks++;
        if (d < 0 || pop_q.size() != 1) begin
            n_fail++; $display("FAIL midreset_job: done=%0d results=%0d expected 1", d, pop_q.size());
        end else if (pop_q[0] !== 17'(exp_pix(0, 1))) begin
            n_fail++; $display("FAIL midreset_val: got %0d expected %0d", pop_q[0], exp_pix(0, 1));
        end
    endtask

    task automatic test_random();
        int d;
        fill_rand();
        res_ready = 1'b0;
        start_job(20, 4);
        wait_done(3000, 1'b1, d);
        res_ready = 1'b1;
        n_checks++;
        if (d < 0 || pop_q.size() != 20) begin
            n_fail++; $display("FAIL random_count: done=%0d results=%0d expected 20", d, pop_q.size());
        end
        for (int i = 0; i < pop_q.size() && i < 20; i++) begin
            n_checks++;
            if (pop_q[i] !== 17'(exp_pix(i, 4))) begin
                n_fail++; $display("FAIL random_res%0d: got %0d expected %0d", i, pop_q[i], exp_pix(i, 4));
            end
        end
`ifdef CONV_SCHED_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'(m_stall)) begin
            n_fail++; $display("FAIL random_stall: got %0d expected %0d", stall_cnt, m_stall);
        end
`endif
    endtask

    task automatic test_monitors();
        n_checks++;
        if (stab_err != 0) begin n_fail++; $display("FAIL res_stable: got %0d violations expected 0", stab_err); end
        n_checks++;
        if (credit_err != 0) begin n_fail++; $display("FAIL fifo_overflow: got %0d over-credit cycles expected 0", credit_err); end
        n_checks++;
        if (mv_err != 0) begin n_fail++; $display("FAIL mac_valid_delay: got %0d mismatched cycles expected 0", mv_err); end
        n_checks++;
        if (pair_err != 0) begin n_fail++; $display("FAIL rd_en_pair: got %0d mismatched cycles expected 0", pair_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_credit();
        test_empty();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_monitors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mac_scheduler.md
Name: conv_mac_scheduler

Overview:
Sequencer for the 32-lane 4-bit convolution MAC array (13-bit partial-sum output, fixed pipeline).
- Fetches one 32-element IFM chunk and one 32-element weight chunk per cycle from the IFM and weight SRAMs.
- Drives the MAC's in_valid/weight_valid and accumulates MAC partial sums over K chunks per output pixel.
- Pushes finished pixels into a small output FIFO with valid/ready backpressure toward the writeback stage.

Parameters:
RD_LAT, 1, SRAM read latency in cycles (rd_en to data at MAC inputs)
MAC_LAT, 4, cycles from mac_in_valid high to the matching mac_ofm
OFM_W, 13, MAC partial-sum width
ACC_W, 17, accumulator and result width (OFM_W + 4)
IFM_AW, 12, IFM SRAM address width
WGT_AW, 4, weight SRAM address width
OUT_DEPTH, 4, output FIFO depth, also the issue credit limit (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse, sampled only in IDLE
cfg_num_pix  in  8  output pixels in the job (0 = empty job)
cfg_num_chunk  in  4  chunks per pixel K (0 = empty job)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job completion
ifm_rd_en  out  1  IFM SRAM read strobe
ifm_rd_addr  out  IFM_AW  IFM chunk address, linear pix*K+k
wgt_rd_en  out  1  weight SRAM read strobe
wgt_rd_addr  out  WGT_AW  weight chunk address = k
mac_in_valid  out  1  load IFM registers of MAC
mac_weight_valid  out  1  load weight registers of MAC
mac_ofm  in  OFM_W  MAC partial sum
res_valid  out  1  result available (FIFO not empty)
res_ready  in  1  downstream accepts result
res_data  out  ACC_W  accumulated pixel result (FIFO head)
stall_cnt  out  16  credit-stall cycle count (optional feature)

Behaviour:
- Reset: FSM in IDLE; every counter, tag pipe and FIFO cleared. busy, done, ifm_rd_en, wgt_rd_en, mac_in_valid, mac_weight_valid, res_valid and stall_cnt are 0; addresses and res_data are 0. Reset mid-job abandons the job; no done pulse follows.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start with both cfg values nonzero latches the config, sets busy and moves to ISSUE. start with either cfg value 0 moves to FIN with no reads.
  - ISSUE: issues one chunk read per cycle when credit is available. After the final chunk (pix=N-1, k=K-1) it moves to DRAIN.
  - DRAIN: waits until the tag pipe is empty and the FIFO is empty (all results accepted), then moves to FIN.
  - FIN: done=1 for one cycle, busy=0 on the next cycle, returns to IDLE.
- start outside IDLE is ignored.
- Issue:
  - ifm_rd_en and wgt_rd_en assert together.
  - ifm_rd_addr increments by 1 per issue; it is a running counter with no multiplier.
  - wgt_rd_addr = k; k wraps K-1 to 0 and pix increments on the wrap.
  - mac_in_valid and mac_weight_valid = rd_en delayed RD_LAT cycles.
- Credit: chunk k=0 of a new pixel issues only if (pixels in flight + FIFO occupancy) < OUT_DEPTH. Chunks 1..K-1 of an already-started pixel never stall.
- Tag pipe: RD_LAT+MAC_LAT stages, each carrying {v, first, last}. When the stage-end entry has v=1, mac_ofm is consumed that cycle:
  - first: acc = zero-extended mac_ofm.
  - otherwise: acc = acc + mac_ofm.
  - last: push the final sum (acc + mac_ofm, or mac_ofm when K=1) into the FIFO. Back-to-back pixels are supported; first and last coincide when K=1.
- FIFO: simultaneous push and pop allowed at any occupancy. Pop when res_valid && res_ready. res_data stays stable while res_valid && !res_ready. Push into a full FIFO cannot occur by construction; the bench asserts this.
- No arithmetic overflow: the maximum result 15*15*32*15 = 108000 fits in 17 bits.

Optional Feature:
- CONV_SCHED_STALL_CNT_EN defined: stall_cnt increments (saturating at 0xFFFF) on every ISSUE cycle where the credit blocks issue. It clears on accepted start and on reset.
- Not defined: stall_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package conv_pkg: FSM state enum, OFM_W/ACC_W/OUT_DEPTH defaults and the tag struct {v, first, last}.
- One natural sub-module, conv_res_fifo: synchronous FIFO with count output, parameterised by width and depth.
- Issue counters, tag pipe and accumulator stay in the top module.

Test Plan:
- IFM=1 and weight=1 everywhere, N=2, K=3, res_ready=1 -> results 96, 96.
  - ifm_rd_addr 0..5, wgt_rd_addr 0,1,2,0,1,2, issued on 6 consecutive cycles.
  - done 1 cycle after the last pop.
- All values 15, N=1, K=15 -> single result 108000; checks no truncation.
- N=8, K=1, res_ready=0 -> exactly 4 issues, then stall.
  - Releasing res_ready yields 8 results in order.
  - With CONV_SCHED_STALL_CNT_EN, stall_cnt is nonzero and matches the blocked cycles.
- start with N=0 -> done pulse within 2 cycles, no rd_en.
  - start during busy -> ignored; config is unchanged.
- Reset asserted mid-ISSUE with N=4, K=2 -> all outputs 0 immediately.
  - A subsequent job N=1, K=1 (value 32) completes correctly.
- Random res_ready toggling, N=20, K=4, random data -> results match the reference model.
  - res_data stays stable under stall.
